// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: RV32I opcodes and instruction formats shared by the decoder and the encoder.
package instr_encoder_pkg;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    function automatic fmt_e op_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_AUIPC, OP_LUI:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            OP_REG:                   f = FMT_R;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction
endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational placement of fields and immediate bits into an RV32I word, with legality check.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    always_comb begin
        word    = {25'd0, opcode};
        illegal = 1'b1;
        case (fmt)
            FMT_R: begin
                word    = {funct7, rs2, rs1, funct3, rd, opcode};
                illegal = 1'b0;
            end
            FMT_I: begin
                word    = {imm[11:0], rs1, funct3, rd, opcode};
                illegal = !(&imm[31:11] || ~|imm[31:11]);
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                illegal = !(&imm[31:11] || ~|imm[31:11]);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = imm[0] || !(&imm[31:12] || ~|imm[31:12]);
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opcode};
                illegal = |imm[11:0];
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = imm[0] || !(&imm[31:20] || ~|imm[31:20]);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage valid/ready RV32I instruction encoder with saturating error counter.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter bit ERR_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    logic        s1_valid;
    fmt_e        s1_fmt;
    logic [6:0]  s1_opcode, s1_funct7;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [2:0]  s1_funct3;
    logic [31:0] s1_imm, word;
    logic        illegal;

    logic s2_load, s1_load;
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    instr_pack u_pack (
        .fmt(s1_fmt), .opcode(s1_opcode), .rd(s1_rd), .rs1(s1_rs1), .rs2(s1_rs2),
        .funct3(s1_funct3), .funct7(s1_funct7), .imm(s1_imm), .word(word), .illegal(illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_fmt    <= FMT_BAD;
            s1_opcode <= '0;
            s1_rd     <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_funct3 <= '0;
            s1_funct7 <= '0;
            s1_imm    <= '0;
            out_valid <= 1'b0;
            instr_out <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_fmt    <= op_fmt(opcode);
                    s1_opcode <= opcode;
                    s1_rd     <= rd;
                    s1_rs1    <= rs1;
                    s1_rs2    <= rs2;
                    s1_funct3 <= funct3;
                    s1_funct7 <= funct7;
                    s1_imm    <= imm;
                end
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    instr_out <= (ERR_ZERO && illegal) ? 32'h0 : word;
                    err       <= illegal;
                end
            end
            if (out_valid && out_ready && err && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule
